sim_deser: RTL and testbench
============================

Name: sim_deser

Overview:
- Verilator-compatible, simulation-only deserializer model placed directly downstream of the phase/divided-clock generator (SIM_DELAY).
- Samples a serial bit stream D on CLK every cycle and treats the divided clock CLKDIV_IN as a synchronous strobe, not as a clock.
- On each CLKDIV_IN rising edge, plus a programmable bitslip offset, emits a DATA_WIDTH-bit parallel word.
- Tracks CLKDIV_IN period to report lock and period errors.

Parameters:
- DATA_WIDTH, 4, parallel word width; legal range 2..8; 4 matches the generator's divide-by-4 output.
- LOCK_COUNT, 3, consecutive correct CLKDIV_IN periods needed to assert LOCKED; legal range 1..15.
- INIT_Q, 0, value of Q after reset.

Ports:
- CLK  in  1  sole clock.
- RST_N  in  1  reset, synchronous, active-low.
- D  in  1  serial data, sampled every CLK rising edge when CE=1.
- CLKDIV_IN  in  1  divided clock from the upstream stage, sampled synchronously.
- CE  in  1  shift/capture enable.
- BITSLIP  in  1  level input; each 0->1 transition advances the capture offset by one.
- Q  out  DATA_WIDTH  captured parallel word; first-received bit in MSB.
- Q_VALID  out  1  one-cycle pulse, high in the cycle Q first shows a new word.
- LOCKED  out  1  CLKDIV_IN period stable at DATA_WIDTH cycles.
- PERIOD_ERR  out  1  one-cycle pulse on a bad period while LOCKED.

Behaviour:
- Reset: the only reset is RST_N=0 sampled at a CLK edge. It clears:
  - Q=INIT_Q; Q_VALID, LOCKED, PERIOD_ERR = 0.
  - Shift register, edge-detect flop, BITSLIP history, slip offset, capture countdown, period counter and good-period count = 0.
  - FSM to HUNT.
  - Reset mid-word discards the partial word.
- Shift register sr[DATA_WIDTH-1:0]: when CE=1, sr <= {sr[W-2:0], D}. When CE=0, sr holds.
- Edge detect:
  - div_q <= CLKDIV_IN every cycle, regardless of CE.
  - rise = CLKDIV_IN & ~div_q, evaluated combinationally in the current cycle.
- Bitslip:
  - slip_q <= BITSLIP; a slip event is BITSLIP & ~slip_q.
  - Each slip event does ofs <= (ofs+1) mod DATA_WIDTH.
  - A slip in the same cycle as rise leaves that rise using the old ofs.
- Capture:
  - On rise, load countdown = ofs.
  - Capture cycle is the rise cycle if ofs=0; otherwise the cycle where countdown, decremented each cycle, reaches 0.
  - In the capture cycle with CE=1: Q <= {sr[W-2:0], D}, i.e. the window includes the bit sampled that cycle.
  - Q_VALID=1 for exactly the following cycle. Latency is 1 CLK from capture cycle to Q/Q_VALID.
  - A new rise while a countdown is pending restarts the countdown; the pending capture is dropped.
  - If CE=0 in the capture cycle, there is no capture and no Q_VALID.
- Period counter per:
  - Increments each cycle, saturating at 2*DATA_WIDTH-1.
  - On rise, the period value is per+1, and per resets to 0.
  - The first rise after reset only starts measurement.
- Lock FSM:
  - HUNT: first rise -> CHECK, with good=0.
  - CHECK, on rise: period==DATA_WIDTH increments good; when good reaches LOCK_COUNT, go to LOCKED. Any other period sets good=0 and stays in CHECK.
  - LOCKED: LOCKED=1. On rise with period!=DATA_WIDTH, or per saturation without a rise, PERIOD_ERR pulses one cycle, LOCKED=0 next cycle, and the FSM goes to CHECK with good=0.
  - Capture operates in every state; LOCKED is advisory only.
- No X propagation: all state is reset, and Q never carries uninitialised bits.

Decomposition:
- Shared package sim_unisim_pkg:
  - lock FSM state enum (HUNT, CHECK, LOCKED_S);
  - constant MAX_DESER_WIDTH=8;
  - helper function clog2 for counter sizing.
- One natural sub-module, sim_period_mon: edge input, period counter, lock FSM, LOCKED/PERIOD_ERR outputs.
- Shift, bitslip and capture logic stay in sim_deser.

Test Plan:
All scenarios use DATA_WIDTH=4, LOCK_COUNT=3, CLKDIV_IN 2 high / 2 low.
1. Reset: hold RST_N=0 for 3 cycles with D toggling and CLKDIV_IN running -> Q=0, Q_VALID=0, LOCKED=0, PERIOD_ERR=0 throughout, and 1 cycle after release.
2. Aligned word: D repeats 1,0,1,1 with the final 1 sampled in the rise cycle -> Q=4'b1011, and Q_VALID pulses once every 4 cycles, 1 cycle after each rise.
3. Lock/error: 3 good periods after the first rise -> LOCKED=1. Then stretch one high phase to 3 cycles (period 5) -> PERIOD_ERR pulses 1 cycle, LOCKED=0, and LOCKED=1 again after 3 further good periods.
4. Bitslip: one BITSLIP 0->1 on stream 1011 -> subsequent Q=4'b0111. After 4 total slip events, Q=4'b1011 again. A slip coincident with a rise changes only later words.
5. CE gating: CE=0 for the 2 cycles including a capture cycle -> no Q_VALID for that word, and sr holds; with CE=1 restored, the next word captures normally.
6. Reset mid-operation: while LOCKED with ofs=2, pulse RST_N=0 for 1 cycle -> Q=0, LOCKED=0, ofs=0; the next captured word is at offset 0 and relock takes 3 good periods after the first rise.

Source files
------------

// File: rtl/sim_unisim_pkg.sv
// Shared types and helpers for the simulation-only deserializer models.
package sim_unisim_pkg;

   localparam int unsigned MAX_DESER_WIDTH = 8;

   typedef enum logic [1:0] {
      Hunt    = 2'd0,
      Check   = 2'd1,
      LockedS = 2'd2
   } lock_state_e;

   // Bits needed to hold values 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/sim_period_mon.sv
// Measures the divided-clock period from its rise strobe and tracks lock.
module sim_period_mon
   import sim_unisim_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned LOCK_COUNT = 3
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic rise_i,
   output logic locked_o,
   output logic period_err_o
);

   localparam int unsigned PerMax = 2 * DATA_WIDTH - 1;
   localparam int unsigned PerW   = clog2(2 * DATA_WIDTH);
   localparam int unsigned GoodW  = clog2(LOCK_COUNT + 1);

   lock_state_e      state_q;
   logic [PerW-1:0]  per_q;
   logic [GoodW-1:0] good_q;
   logic             locked_q;
   logic             err_q;

   logic [PerW:0] period;
   logic          period_ok;
   logic          per_sat;
   logic          good_done;

   // Period seen at a rise counts the rise cycle itself, hence the +1.
   assign period    = {1'b0, per_q} + (PerW+1)'(1);
   assign period_ok = (period == (PerW+1)'(DATA_WIDTH));
   assign per_sat   = (per_q == PerW'(PerMax));
   assign good_done = ((good_q + GoodW'(1)) == GoodW'(LOCK_COUNT));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= Hunt;
         per_q    <= '0;
         good_q   <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (rise_i) begin
            per_q <= '0;
         end else if (!per_sat) begin
            per_q <= per_q + PerW'(1);
         end

         case (state_q)
            Hunt: begin
               if (rise_i) begin
                  state_q <= Check;
                  good_q  <= '0;
               end
            end
            Check: begin
               if (rise_i) begin
                  if (!period_ok) begin
                     good_q <= '0;
                  end else if (good_done) begin
                     state_q  <= LockedS;
                     locked_q <= 1'b1;
                     good_q   <= '0;
                  end else begin
                     good_q <= good_q + GoodW'(1);
                  end
               end
            end
            LockedS: begin
               // A missing rise is caught once the counter saturates.
               if ((rise_i && !period_ok) || (!rise_i && per_sat)) begin
                  state_q  <= Check;
                  locked_q <= 1'b0;
                  err_q    <= 1'b1;
                  good_q   <= '0;
               end
            end
            default: begin
               state_q  <= Hunt;
               locked_q <= 1'b0;
               good_q   <= '0;
            end
         endcase
      end
   end

   assign locked_o     = locked_q;
   assign period_err_o = err_q;

endmodule

// File: rtl/sim_deser.sv
// Simulation deserializer: shifts D every CLK and captures a word per CLKDIV_IN
// rise, delayed by a bitslip-controlled offset.
module sim_deser
   import sim_unisim_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH = 4,
   parameter int unsigned             LOCK_COUNT = 3,
   parameter logic [DATA_WIDTH-1:0]   INIT_Q     = '0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  D,
   input  logic                  CLKDIV_IN,
   input  logic                  CE,
   input  logic                  BITSLIP,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  Q_VALID,
   output logic                  LOCKED,
   output logic                  PERIOD_ERR
);

   localparam int unsigned OfsW = clog2(DATA_WIDTH);

   // Only the W-1 newest bits are ever needed: the capture window adds D itself.
   logic [DATA_WIDTH-2:0] hist_q;
   logic [DATA_WIDTH-1:0] q_q;
   logic                  valid_q;
   logic                  div_q;
   logic                  slip_q;
   logic [OfsW-1:0]       ofs_q, ofs_d;
   logic [OfsW-1:0]       cnt_q, cnt_d;
   logic                  pend_q, pend_d;

   logic                  rise;
   logic                  slip_ev;
   logic                  capture;
   logic [DATA_WIDTH-1:0] window;

   assign rise    = CLKDIV_IN & ~div_q;
   assign slip_ev = BITSLIP & ~slip_q;
   assign window  = {hist_q, D};
   assign capture = (rise && (ofs_q == '0)) ||
                    (!rise && pend_q && (cnt_q == OfsW'(1)));

   always_comb begin
      ofs_d  = ofs_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      if (slip_ev) begin
         ofs_d = (ofs_q == OfsW'(DATA_WIDTH - 1)) ? '0 : ofs_q + OfsW'(1);
      end
      // A rise restarts the countdown, dropping any capture still pending.
      if (rise) begin
         cnt_d  = ofs_q;
         pend_d = (ofs_q != '0);
      end else if (pend_q) begin
         cnt_d  = cnt_q - OfsW'(1);
         pend_d = (cnt_q != OfsW'(1));
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         hist_q  <= '0;
         q_q     <= INIT_Q;
         valid_q <= 1'b0;
         div_q   <= 1'b0;
         slip_q  <= 1'b0;
         ofs_q   <= '0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         div_q   <= CLKDIV_IN;
         slip_q  <= BITSLIP;
         ofs_q   <= ofs_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         valid_q <= capture & CE;
         if (CE) begin
            hist_q <= window[DATA_WIDTH-2:0];
         end
         if (capture && CE) begin
            q_q <= window;
         end
      end
   end

   sim_period_mon #(
      .DATA_WIDTH (DATA_WIDTH),
      .LOCK_COUNT (LOCK_COUNT)
   ) u_period_mon (
      .clk_i        (CLK),
      .rst_ni       (RST_N),
      .rise_i       (rise),
      .locked_o     (LOCKED),
      .period_err_o (PERIOD_ERR)
   );

   assign Q       = q_q;
   assign Q_VALID = valid_q;

endmodule

// File: tb/tb_sim_deser.sv
// Bench for sim_deser: vector table, directed multi-cycle sequences, random run
// against a timestamp-based reference model.
module tb_sim_deser;

   localparam int W  = 4;
   localparam int LC = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         d = 1'b0;
   logic         div = 1'b0;
   logic         ce = 1'b1;
   logic         bs = 1'b0;
   logic [W-1:0] q;
   logic         qv, lk, pe;

   sim_deser #(
      .DATA_WIDTH (W),
      .LOCK_COUNT (LC),
      .INIT_Q     (4'b0000)
   ) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .D          (d),
      .CLKDIV_IN  (div),
      .CE         (ce),
      .BITSLIP    (bs),
      .Q          (q),
      .Q_VALID    (qv),
      .LOCKED     (lk),
      .PERIOD_ERR (pe)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_fail = 0;
   bit   model_on = 1'b0;
   int   vcnt = 0;
   int   ecnt = 0;
   logic [3:0] pat_v = 4'b1011;

   // Reference model state: time stamps and bit history, not register images.
   int           cyc = 0;
   bit           hist[$];
   bit           m_pdiv, m_pslip, seen, m_lk;
   int           m_slips, cap_at, last_rise, good;
   logic [W-1:0] e_q;
   bit           e_v, e_er;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_step(input bit r, input bit dd, input bit dv, input bit c, input bit s);
      bit           rise, sev;
      int           ofs, p;
      logic [W-1:0] win;
      if (!r) begin
         hist.delete();
         for (int i = 0; i < W - 1; i++) hist.push_back(1'b0);
         m_pdiv = 0; m_pslip = 0; m_slips = 0; cap_at = -1; last_rise = -1;
         seen = 0; m_lk = 0; good = 0; e_q = '0; e_v = 0; e_er = 0;
      end else begin
         rise = dv && !m_pdiv;
         sev  = s && !m_pslip;
         ofs  = m_slips % W;
         e_v  = 0;
         e_er = 0;
         for (int i = 0; i < W - 1; i++) win[W-1-i] = hist[i];
         win[0] = dd;
         if (rise) cap_at = cyc + ofs;
         if (cap_at == cyc) begin
            if (c) begin
               e_q = win;
               e_v = 1;
            end
            cap_at = -1;
         end
         if (c) begin
            hist.push_back(dd);
            void'(hist.pop_front());
         end
         if (rise) begin
            if (!seen) begin
               seen = 1;
               good = 0;
            end else begin
               p = cyc - last_rise;
               if (p > 2 * W) p = 2 * W;
               if (m_lk) begin
                  if (p != W) begin
                     e_er = 1; m_lk = 0; good = 0;
                  end
               end else if (p == W) begin
                  good++;
                  if (good == LC) m_lk = 1;
               end else begin
                  good = 0;
               end
            end
            last_rise = cyc;
         end else if (m_lk && (cyc - last_rise >= 2 * W)) begin
            e_er = 1; m_lk = 0; good = 0;
         end
         m_slips += int'(sev);
         m_pdiv  = dv;
         m_pslip = s;
      end
      cyc++;
   endtask

   task automatic step(input bit r, input bit dd, input bit dv, input bit c, input bit s);
      rst_n = r; d = dd; div = dv; ce = c; bs = s;
      model_step(r, dd, dv, c, s);
      @(posedge clk);
      #1;
      if (qv) vcnt++;
      if (pe) ecnt++;
      if (model_on) begin
         chk("model_q", q, e_q);
         chk("model_valid", qv, e_v);
         chk("model_locked", lk, m_lk);
         chk("model_err", pe, e_er);
      end
   endtask

   // One CLKDIV period with D = 1011 aligned so the last 1 lands on the rise.
   task automatic per4(input int nh, input int nl, input int slip_at, input int ce_lo);
      vcnt = 0;
      ecnt = 0;
      for (int j = 0; j < nh + nl; j++) begin
         step(1'b1, pat_v[3 - ((j + 3) % 4)], j < nh,
              !(ce_lo >= 0 && j >= ce_lo && j < ce_lo + 2), j == slip_at);
      end
   endtask

   typedef struct {
      bit           r, dd, dv, c, s;
      logic [W-1:0] eq;
      bit           ev, elk, eer;
   } vec_t;

   vec_t tbl [0:16];

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b0, 1'b0};

      // Reset and first aligned words.
      for (int i = 0; i <= 16; i++) begin
         step(tbl[i].r, tbl[i].dd, tbl[i].dv, tbl[i].c, tbl[i].s);
         chk("tbl_q", q, tbl[i].eq);
         chk("tbl_valid", qv, tbl[i].ev);
         chk("tbl_locked", lk, tbl[i].elk);
         chk("tbl_err", pe, tbl[i].eer);
      end
      model_on = 1'b1;

      // Lock, stretched period, relock.
      per4(2, 2, -1, -1);
      chk("locked_after_3_good", lk, 1);
      per4(3, 2, -1, -1);
      chk("no_err_during_stretch", ecnt, 0);
      per4(2, 2, -1, -1);
      chk("err_pulse_once", ecnt, 1);
      chk("unlocked_after_err", lk, 0);
      per4(2, 2, -1, -1);
      per4(2, 2, -1, -1);
      chk("not_relocked_early", lk, 0);
      per4(2, 2, -1, -1);
      chk("relocked", lk, 1);

      // Bitslip: first slip coincides with a rise and must not affect that word.
      per4(2, 2, 0, -1);
      chk("slip_on_rise_old_ofs", q, 4'b1011);
      per4(2, 2, -1, -1);
      chk("slip1_word", q, 4'b0111);
      chk("slip1_one_valid", vcnt, 1);
      per4(2, 2, 2, -1);
      chk("slip2_pending_word", q, 4'b0111);
      per4(2, 2, 2, -1);
      chk("slip2_word", q, 4'b1110);
      per4(2, 2, 2, -1);
      chk("slip3_word", q, 4'b1101);
      per4(2, 2, -1, -1);
      chk("slip4_wraps", q, 4'b1011);

      // CE low across the capture cycle.
      per4(2, 2, -1, 0);
      chk("ce_no_valid", vcnt, 0);
      chk("ce_q_held", q, 4'b1011);
      per4(2, 2, -1, -1);
      chk("ce_resume_valid", vcnt, 1);
      chk("ce_resume_q", q, 4'b1011);

      // Missing rise while locked: saturation error.
      per4(2, 10, -1, -1);
      chk("sat_err_once", ecnt, 1);
      chk("sat_unlocked", lk, 0);
      per4(2, 2, -1, -1);
      chk("no_err_in_check", ecnt, 0);
      per4(2, 2, -1, -1);
      per4(2, 2, -1, -1);
      per4(2, 2, -1, -1);
      chk("relocked_after_sat", lk, 1);

      // Reset while locked with offset 2.
      per4(2, 2, 2, -1);
      per4(2, 2, 2, -1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("midrst_q", q, 4'b0000);
      chk("midrst_locked", lk, 0);
      per4(2, 2, -1, -1);
      chk("midrst_word_ofs0", q, 4'b0001);
      chk("midrst_one_valid", vcnt, 1);
      per4(2, 2, -1, -1);
      per4(2, 2, -1, -1);
      chk("midrst_not_locked_yet", lk, 0);
      per4(2, 2, -1, -1);
      chk("midrst_relocked", lk, 1);

      // Random periods, CE, slips, data and rare resets.
      for (int k = 0; k < 150; k++) begin
         int nh, nl;
         if ($urandom_range(0, 3) != 0) begin
            nh = 2; nl = 2;
         end else begin
            nh = $urandom_range(1, 3);
            nl = ($urandom_range(0, 7) == 0) ? 10 : $urandom_range(1, 3);
         end
         for (int j = 0; j < nh + nl; j++) begin
            step($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1, j < nh,
                 $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
